axi_wr_arbiter: RTL
===================

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 SHALL have parameter SLAVE_NUM, default 2: number of requesting AXI write ports.
REQ-002 SHALL have parameter ID_WIDTH, default 4: AXI ID width, passed through unchanged.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: AW address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 32: W data width; strobe width is DATA_WIDTH/8.
REQ-005 SHALL have parameter LEN_WIDTH, default 8: AW burst length width.
REQ-006 SHALL have parameter BQ_DEPTH, default 4 (power of 2): number of outstanding B responses tracked.
REQ-007 SHALL have port aclk, input, 1: the single clock; all logic is rising-edge.
REQ-008 SHALL have port areset, input, 1: reset, asynchronous and active-high.
REQ-009 SHALL have ports s_awid/s_awaddr/s_awlen/s_awsize/s_awburst, input, SLAVE_NUM x field width, packed with port 0 in the LSBs: AW payload per port.
REQ-010 SHALL have ports s_awvalid (input) and s_awready (output), SLAVE_NUM: AW handshake per port.
REQ-011 SHALL have ports s_wid/s_wdata/s_wstrb/s_wlast/s_wvalid (input) and s_wready (output), SLAVE_NUM x field width, packed: W channel per port.
REQ-012 SHALL have ports s_bid/s_bresp/s_bvalid (output) and s_bready (input), SLAVE_NUM x field width, packed: B channel per port.
REQ-013 SHALL have ports m_awid/m_awaddr/m_awlen/m_awsize/m_awburst/m_awvalid (output) and m_awready (input), single width: shared AW master.
REQ-014 SHALL have ports m_wid/m_wdata/m_wstrb/m_wlast/m_wvalid (output) and m_wready (input): shared W master.
REQ-015 SHALL have ports m_bid/m_bresp/m_bvalid (input) and m_bready (output): shared B master.

Function
REQ-016 SHALL implement FSM states IDLE, ADDR and DATA.
REQ-017 In IDLE with the B queue not full, SHALL select one requesting port round-robin, starting the search at (last_grant+1) mod SLAVE_NUM.
REQ-018 In the same IDLE cycle, SHALL assert s_awready only for the winner, register its AW payload, record the grant index, and go to ADDR.
REQ-019 In IDLE with no s_awvalid asserted, or with the B queue full, SHALL assert no s_awready bit and stay in IDLE.
REQ-020 In ADDR, SHALL drive m_awvalid=1 with the registered payload held stable until m_awready; on that handshake, SHALL push the grant index into the B queue and go to DATA.
REQ-021 In DATA, SHALL connect the W channel combinationally: m_w* = s_w*[grant]; s_wready[grant] = m_wready; all other s_wready bits = 0.
REQ-022 SHALL return from DATA to IDLE on the cycle with m_wvalid & m_wready & m_wlast; a new grant is possible the following cycle.
REQ-023 Outside DATA, SHALL hold m_wvalid=0 and all s_wready bits 0.
REQ-024 With the B queue non-empty, SHALL route B to the head port h: s_bvalid[h] = m_bvalid, s_b*[h] = m_b*, m_bready = s_bready[h].
REQ-025 With the B queue non-empty, SHALL hold s_bvalid of every port other than h at 0.
REQ-026 With the B queue empty, SHALL hold m_bready=0 and all s_bvalid bits 0.
REQ-027 SHALL pop the B queue on m_bvalid & m_bready.
REQ-028 A push and a pop in the same cycle SHALL leave the queue count unchanged.
REQ-029 Queue fullness SHALL be evaluated from the registered count only, so a same-cycle pop does not unblock a grant.
REQ-030 SHALL keep read and write pointers log2(BQ_DEPTH) bits wide, wrapping modulo BQ_DEPTH, with a count of log2(BQ_DEPTH)+1 bits.
REQ-031 A zero-length burst (awlen=0) SHALL complete DATA after exactly one W beat.

Reset
REQ-032 While areset=1, SHALL force state IDLE, last_grant=SLAVE_NUM-1 (so port 0 wins first), B queue empty, and m_awvalid=0, all s_awready bits 0, m_bready=0.
REQ-033 Reset asserted mid-burst SHALL abandon the burst and clear all queued B entries; no response is owed after reset.

Configuration
REQ-034 With AXI_WR_ARB_PRIO_EN defined, SHALL add input prio_en (1 bit); when prio_en=1, the IDLE selection is fixed priority with the lowest index winning and last_grant not updated.
REQ-035 With AXI_WR_ARB_PRIO_EN undefined, SHALL omit the prio_en port and use round-robin only.

Structure
REQ-036 SHALL place FSM state encodings and the AXI BRESP constants in shared package axi_pkg.
REQ-037 SHALL implement the B queue as sub-module axi_wr_arb_bq (synchronous FIFO of grant indices with full and empty flags).

Verification
REQ-038 Bench: both ports raise AW together from reset -> port 0 is granted first, then port 1; alternation continues for 8 bursts.
REQ-039 Bench: port 1 issues a len=15 burst while port 0 requests -> port 0 gets no s_awready until the cycle after the 16th W beat's wlast handshake.
REQ-040 Bench: m_bready stall with BQ_DEPTH=4 and 5 back-to-back single-beat bursts -> the 5th s_awready is withheld until the first B handshake.
REQ-041 Bench: responses with bresp=2'b10 on the 2nd burst -> delivered only to the port that issued the 2nd burst, in issue order.
REQ-042 Bench: areset pulsed during the DATA beat 3 of 8 -> all outputs at reset values, the queue is empty, and the next grant goes to port 0.
REQ-043 Bench: with AXI_WR_ARB_PRIO_EN defined, prio_en=1 and both ports requesting continuously -> port 0 is granted on every arbitration.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared definitions for the AXI write arbiter: FSM state encodings and BRESP codes.
package axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_wr_arb_bq.sv
// B-response ordering queue: FIFO of grant indices, one entry per accepted AW,
// popped when the matching B handshake completes.
module axi_wr_arb_bq #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_idx,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_idx;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/axi_wr_arbiter.sv
// N:1 AXI write arbiter: round-robin AW grant, W routed to the granted port, B routed
// in issue order. Define AXI_WR_ARB_PRIO_EN to add the prio_en fixed-priority input.
module axi_wr_arbiter
  import axi_pkg::*;
#(
  parameter int SLAVE_NUM  = 2,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int BQ_DEPTH   = 4
) (
  input  logic                              aclk,
  input  logic                              areset,
`ifdef AXI_WR_ARB_PRIO_EN
  input  logic                              prio_en,
`endif
  input  logic [SLAVE_NUM*ID_WIDTH-1:0]     s_awid,
  input  logic [SLAVE_NUM*ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [SLAVE_NUM*LEN_WIDTH-1:0]    s_awlen,
  input  logic [SLAVE_NUM*3-1:0]            s_awsize,
  input  logic [SLAVE_NUM*2-1:0]            s_awburst,
  input  logic [SLAVE_NUM-1:0]              s_awvalid,
  output logic [SLAVE_NUM-1:0]              s_awready,
  input  logic [SLAVE_NUM*ID_WIDTH-1:0]     s_wid,
  input  logic [SLAVE_NUM*DATA_WIDTH-1:0]   s_wdata,
  input  logic [SLAVE_NUM*DATA_WIDTH/8-1:0] s_wstrb,
  input  logic [SLAVE_NUM-1:0]              s_wlast,
  input  logic [SLAVE_NUM-1:0]              s_wvalid,
  output logic [SLAVE_NUM-1:0]              s_wready,
  output logic [SLAVE_NUM*ID_WIDTH-1:0]     s_bid,
  output logic [SLAVE_NUM*2-1:0]            s_bresp,
  output logic [SLAVE_NUM-1:0]              s_bvalid,
  input  logic [SLAVE_NUM-1:0]              s_bready,
  output logic [ID_WIDTH-1:0]               m_awid,
  output logic [ADDR_WIDTH-1:0]             m_awaddr,
  output logic [LEN_WIDTH-1:0]              m_awlen,
  output logic [2:0]                        m_awsize,
  output logic [1:0]                        m_awburst,
  output logic                              m_awvalid,
  input  logic                              m_awready,
  output logic [ID_WIDTH-1:0]               m_wid,
  output logic [DATA_WIDTH-1:0]             m_wdata,
  output logic [DATA_WIDTH/8-1:0]           m_wstrb,
  output logic                              m_wlast,
  output logic                              m_wvalid,
  input  logic                              m_wready,
  input  logic [ID_WIDTH-1:0]               m_bid,
  input  logic [1:0]                        m_bresp,
  input  logic                              m_bvalid,
  output logic                              m_bready
);

  localparam int IDX_W  = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  arb_state_t              r_state;
  logic [IDX_W-1:0]        r_grant;
  logic [IDX_W-1:0]        r_last_grant;
  logic                    r_awvalid;
  logic [ID_WIDTH-1:0]     r_awid;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [LEN_WIDTH-1:0]    r_awlen;
  logic [2:0]              r_awsize;
  logic [1:0]              r_awburst;

  logic [IDX_W-1:0]        w_winner;
  logic                    w_found;
  logic                    w_prio;
  logic                    w_grant_ok;
  logic                    w_in_data;
  logic                    w_wlast_hs;
  logic                    w_bq_push;
  logic                    w_bq_pop;
  logic                    w_bq_full;
  logic                    w_bq_empty;
  logic [IDX_W-1:0]        w_bq_head;

`ifdef AXI_WR_ARB_PRIO_EN
  assign w_prio = prio_en;
`else
  assign w_prio = 1'b0;
`endif

  // Search starts one past the previous winner; fixed priority starts at port 0.
  always_comb begin
    int               start_idx;
    logic [IDX_W-1:0] cand;
    w_found   = 1'b0;
    w_winner  = '0;
    cand      = '0;
    start_idx = w_prio ? 0 : (int'(r_last_grant) + 1) % SLAVE_NUM;
    for (int k = 0; k < SLAVE_NUM; k++) begin
      cand = IDX_W'((start_idx + k) % SLAVE_NUM);
      if (!w_found && s_awvalid[cand]) begin
        w_found  = 1'b1;
        w_winner = cand;
      end
    end
  end

  assign w_grant_ok = !areset && (r_state == ST_IDLE) && !w_bq_full && w_found;

  always_comb begin
    s_awready = '0;
    if (w_grant_ok) begin
      s_awready[w_winner] = 1'b1;
    end
  end

  assign w_in_data  = (r_state == ST_DATA);
  assign w_wlast_hs = m_wvalid && m_wready && m_wlast;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(SLAVE_NUM - 1);
      r_awvalid    <= 1'b0;
      r_awid       <= '0;
      r_awaddr     <= '0;
      r_awlen      <= '0;
      r_awsize     <= '0;
      r_awburst    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_ok) begin
            r_grant   <= w_winner;
            if (!w_prio) begin
              r_last_grant <= w_winner;
            end
            r_awid    <= s_awid[w_winner*ID_WIDTH +: ID_WIDTH];
            r_awaddr  <= s_awaddr[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
            r_awlen   <= s_awlen[w_winner*LEN_WIDTH +: LEN_WIDTH];
            r_awsize  <= s_awsize[w_winner*3 +: 3];
            r_awburst <= s_awburst[w_winner*2 +: 2];
            r_awvalid <= 1'b1;
            r_state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_awready) begin
            r_awvalid <= 1'b0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_wlast_hs) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_awid    = r_awid;
  assign m_awaddr  = r_awaddr;
  assign m_awlen   = r_awlen;
  assign m_awsize  = r_awsize;
  assign m_awburst = r_awburst;
  assign m_awvalid = r_awvalid;

  assign m_wid    = s_wid[r_grant*ID_WIDTH +: ID_WIDTH];
  assign m_wdata  = s_wdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
  assign m_wstrb  = s_wstrb[r_grant*STRB_W +: STRB_W];
  assign m_wlast  = s_wlast[r_grant];
  assign m_wvalid = w_in_data && s_wvalid[r_grant];

  assign w_bq_push = (r_state == ST_ADDR) && m_awready;
  assign m_bready  = !w_bq_empty && s_bready[w_bq_head];
  assign w_bq_pop  = m_bvalid && m_bready;

  // B payload fans out to every port; only the queue head sees bvalid.
  for (genvar gi = 0; gi < SLAVE_NUM; gi++) begin : g_port
    assign s_wready[gi]                      = w_in_data && (r_grant == IDX_W'(gi)) && m_wready;
    assign s_bvalid[gi]                      = !w_bq_empty && (w_bq_head == IDX_W'(gi)) && m_bvalid;
    assign s_bid[gi*ID_WIDTH +: ID_WIDTH]    = m_bid;
    assign s_bresp[gi*2 +: 2]                = m_bresp;
  end

  axi_wr_arb_bq #(
    .DEPTH (BQ_DEPTH),
    .WIDTH (IDX_W)
  ) u_bq (
    .i_clk      (aclk),
    .i_rst      (areset),
    .i_push     (w_bq_push),
    .i_push_idx (r_grant),
    .i_pop      (w_bq_pop),
    .o_head     (w_bq_head),
    .o_full     (w_bq_full),
    .o_empty    (w_bq_empty)
  );

endmodule
